// File: rtl/fcpu_pkg.sv
// Shared fcpu types: opcodes and bimodal predictor counter helpers.
// Imported by the branch predictor and its history table.
package fcpu_pkg;

   localparam int INSTR_W = 4;

   typedef enum logic [INSTR_W-1:0] {
      I_NOP  = 4'd0,
      I_ALU  = 4'd1,
      I_LD   = 4'd2,
      I_ST   = 4'd3,
      I_BLT  = 4'd4,
      I_BEQ  = 4'd5,
      I_JMP  = 4'd6,
      I_JMPR = 4'd7
   } opcode_t;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
   localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
   localparam bht_ctr_t BHT_WEAK_T    = 2'b10;
   localparam bht_ctr_t BHT_STRONG_T  = 2'b11;

   function automatic bht_ctr_t bht_next(input bht_ctr_t ctr,
                                         input logic taken);
      bht_ctr_t nxt;
      nxt = ctr;
      unique case (1'b1)
         taken && (ctr != BHT_STRONG_T):   nxt = ctr + 2'd1;
         !taken && (ctr != BHT_STRONG_NT): nxt = ctr - 2'd1;
         default: ;
      endcase
      return nxt;
   endfunction

   function automatic logic is_cond_br(input logic [INSTR_W-1:0] op);
      return (op == I_BLT) || (op == I_BEQ);
   endfunction

endpackage

// File: rtl/branch_history_table.sv
// Bimodal 2-bit counter table: one async read port, one
// read-modify-write training port that saturates in place.
import fcpu_pkg::*;

module branch_history_table #(
   parameter int BHT_W = 6
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [BHT_W-1:0] rd_idx,
   output bht_ctr_t         rd_ctr,
   input  logic             wr_en,
   input  logic [BHT_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam int N = 2 ** BHT_W;

   bht_ctr_t tbl [N];

   assign rd_ctr = tbl[rd_idx];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < N; i++) tbl[i] <= BHT_WEAK_NT;
      end else if (wr_en) begin
         tbl[wr_idx] <= bht_next(tbl[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Dispatch-time direction predictor with commit-time training
// and a one-cycle flush request on mispredict.
import fcpu_pkg::*;

module branch_predictor #(
   parameter int BHT_W        = 6,
   parameter int ADDR_W       = 16,
   parameter int N_STATIONS_W = 4,
   parameter int CNT_W        = 32
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    clear,
   input  logic                    q_valid,
   output logic                    q_ready,
   input  logic [ADDR_W-1:0]       q_pc,
   input  logic [INSTR_W-1:0]      q_opcode,
   input  logic [N_STATIONS_W-1:0] q_rob_id,
   output logic                    pred_condition,
   input  logic                    commit_valid,
   input  logic [INSTR_W-1:0]      commit_opcode,
   input  logic [N_STATIONS_W-1:0] commit_id,
   input  logic                    true_condition,
   input  logic                    pred_miss,
   output logic                    flush_req,
   output logic [CNT_W-1:0]        n_branches,
   output logic [CNT_W-1:0]        n_misses
);

   localparam int NS = 2 ** N_STATIONS_W;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NS-1:0]    pend_valid;
   logic [BHT_W-1:0] idx_tbl [NS];

   logic [BHT_W-1:0] q_idx;
   logic             q_cond;
   logic             q_fire;
   logic             c_act;
   logic             c_cond;
   logic             c_train;
   bht_ctr_t         rd_ctr;
   logic             unused_pc;

   assign q_idx     = q_pc[BHT_W-1:0];
   assign unused_pc = ^q_pc[ADDR_W-1:BHT_W];
   assign q_cond    = is_cond_br(q_opcode);
   assign q_ready   = nrst & ~flush_req & ~clear;
   assign q_fire    = q_valid & q_ready;

   // A commit arriving while the flush request is up belongs to
   // work the ROB is already discarding.
   assign c_act   = commit_valid & ~flush_req;
   assign c_cond  = is_cond_br(commit_opcode);
   assign c_train = c_act & c_cond & pend_valid[commit_id];

   branch_history_table #(
      .BHT_W (BHT_W)
   ) u_bht (
      .clk      (clk),
      .nrst     (nrst),
      .rd_idx   (q_idx),
      .rd_ctr   (rd_ctr),
      .wr_en    (c_train),
      .wr_idx   (idx_tbl[commit_id]),
      .wr_taken (true_condition)
   );

   always_comb begin
      pred_condition = 1'b0;
      unique case (1'b1)
         q_cond:              pred_condition = rd_ctr[1];
         q_opcode == I_JMP:   pred_condition = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pend_valid <= '0;
         for (int i = 0; i < NS; i++) idx_tbl[i] <= '0;
      end else if (clear || flush_req) begin
         pend_valid <= '0;
      end else begin
         if (c_train) pend_valid[commit_id] <= 1'b0;
         // Reallocation by the query overrides the commit's release.
         if (q_fire) begin
            pend_valid[q_rob_id] <= q_cond;
            if (q_cond) idx_tbl[q_rob_id] <= q_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         flush_req  <= 1'b0;
         n_branches <= '0;
         n_misses   <= '0;
      end else begin
         flush_req <= c_act & pred_miss;
         if (c_act && c_cond && !(&n_branches))
            n_branches <= n_branches + CNT_ONE;
         if (c_act && pred_miss && !(&n_misses))
            n_misses <= n_misses + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor plus an
// asynchronous reset sequence.
import fcpu_pkg::*;

module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        nrst;
   logic        clear;
   logic        q_valid;
   logic        q_ready;
   logic [15:0] q_pc;
   logic [3:0]  q_opcode;
   logic [3:0]  q_rob_id;
   logic        pred_condition;
   logic        commit_valid;
   logic [3:0]  commit_opcode;
   logic [3:0]  commit_id;
   logic        true_condition;
   logic        pred_miss;
   logic        flush_req;
   logic [31:0] n_branches;
   logic [31:0] n_misses;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk            (clk),
      .nrst           (nrst),
      .clear          (clear),
      .q_valid        (q_valid),
      .q_ready        (q_ready),
      .q_pc           (q_pc),
      .q_opcode       (q_opcode),
      .q_rob_id       (q_rob_id),
      .pred_condition (pred_condition),
      .commit_valid   (commit_valid),
      .commit_opcode  (commit_opcode),
      .commit_id      (commit_id),
      .true_condition (true_condition),
      .pred_miss      (pred_miss),
      .flush_req      (flush_req),
      .n_branches     (n_branches),
      .n_misses       (n_misses)
   );

   typedef struct {
      logic        qv;
      logic [3:0]  qop;
      logic [15:0] pc;
      logic [3:0]  rid;
      logic        cv;
      logic [3:0]  cop;
      logic [3:0]  cid;
      logic        tc;
      logic        pm;
      logic        clr;
      logic        e_pred;
      logic        e_rdy;
      logic        e_flush;
      logic [31:0] e_nb;
      logic [31:0] e_nm;
   } vec_t;

   vec_t tv [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic qv, input opcode_t qop, input logic [15:0] pc,
      input logic [3:0] rid, input logic cv, input opcode_t cop,
      input logic [3:0] cid, input logic tc, input logic pm,
      input logic clr, input logic ep, input logic er,
      input logic ef, input int enb, input int enm);
      vec_t v;
      v.qv = qv; v.qop = qop; v.pc = pc; v.rid = rid;
      v.cv = cv; v.cop = cop; v.cid = cid; v.tc = tc;
      v.pm = pm; v.clr = clr; v.e_pred = ep; v.e_rdy = er;
      v.e_flush = ef; v.e_nb = enb; v.e_nm = enm;
      return v;
   endfunction

   task automatic idle_inputs();
      clear = 0; q_valid = 0; q_pc = '0; q_opcode = I_NOP;
      q_rob_id = '0; commit_valid = 0; commit_opcode = I_NOP;
      commit_id = '0; true_condition = 0; pred_miss = 0;
   endtask

   initial begin
      // qv qop pc rid | cv cop cid tc pm | clr | pred rdy flush nb nm
      tv.push_back(mk(1,I_BEQ ,16'h0005, 1, 0,I_NOP , 0,0,0, 0, 0,1,0, 0,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 2, 1,I_BEQ , 1,1,0, 0, 0,1,0, 1,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 3, 1,I_BEQ , 2,1,0, 0, 1,1,0, 2,0));
      tv.push_back(mk(1,I_BLT ,16'h0045, 4, 1,I_BEQ , 3,0,0, 0, 1,1,0, 3,0));
      tv.push_back(mk(1,I_BEQ ,16'h0105, 5, 1,I_BEQ , 4,0,0, 0, 1,1,0, 4,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 6, 1,I_BEQ , 5,0,0, 0, 0,1,0, 5,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 7, 1,I_BEQ , 6,0,0, 0, 0,1,0, 6,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 8, 1,I_BEQ , 7,0,0, 0, 0,1,0, 7,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 9, 1,I_BEQ , 8,1,0, 0, 0,1,0, 8,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005,10, 1,I_BEQ , 9,1,0, 0, 0,1,0, 9,0));
      tv.push_back(mk(1,I_BEQ ,16'h0005,11, 0,I_NOP , 0,0,0, 0, 1,1,0, 9,0));
      tv.push_back(mk(1,I_BLT ,16'h0007,12, 0,I_NOP , 0,0,0, 0, 0,1,0, 9,0));
      tv.push_back(mk(1,I_JMP ,16'h0005,13, 0,I_NOP , 0,0,0, 0, 1,1,0, 9,0));
      tv.push_back(mk(1,I_JMPR,16'h0005,14, 0,I_NOP , 0,0,0, 0, 0,1,0, 9,0));
      tv.push_back(mk(0,I_NOP ,16'h0005, 0, 1,I_JMPR,14,1,1, 0, 0,1,1, 9,1));
      tv.push_back(mk(1,I_BEQ ,16'h0005,15, 1,I_BEQ ,11,1,1, 0, 1,0,0, 9,1));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 0, 1,I_BEQ ,11,0,0, 0, 1,1,0,10,1));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 1, 1,I_BLT , 0,0,1, 0, 1,1,1,11,2));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 2, 0,I_NOP , 0,0,0, 0, 0,0,0,11,2));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 3, 1,I_BEQ , 1,1,0, 0, 0,1,0,12,2));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 4, 0,I_NOP , 0,0,0, 0, 0,1,0,12,2));
      tv.push_back(mk(1,I_BEQ ,16'h0009, 3, 1,I_BEQ , 3,1,0, 0, 0,1,0,13,2));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 5, 1,I_BEQ , 3,1,0, 0, 1,1,0,14,2));
      tv.push_back(mk(1,I_BLT ,16'h0009, 6, 0,I_NOP , 0,0,0, 0, 1,1,0,14,2));
      tv.push_back(mk(1,I_BEQ ,16'h0005, 7, 0,I_NOP , 0,0,0, 1, 1,0,0,14,2));
      tv.push_back(mk(1,I_BEQ ,16'h0009, 8, 1,I_BEQ , 6,0,0, 0, 1,1,0,15,2));
      tv.push_back(mk(1,I_BEQ ,16'h0009, 9, 0,I_NOP , 0,0,0, 0, 1,1,0,15,2));
      tv.push_back(mk(0,I_NOP ,16'h0000, 0, 1,I_JMPR, 2,0,1, 0, 0,1,1,15,3));

      idle_inputs();
      nrst = 0;
      q_valid = 1; q_opcode = I_BEQ; q_pc = 16'h0005;
      #3;
      chk("reset q_ready", q_ready, 0);
      chk("reset pred", pred_condition, 0);
      chk("reset flush", flush_req, 0);
      chk("reset n_branches", n_branches, 0);
      chk("reset n_misses", n_misses, 0);
      @(negedge clk);
      @(negedge clk);
      nrst = 1;

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         q_valid = tv[i].qv; q_opcode = tv[i].qop;
         q_pc = tv[i].pc; q_rob_id = tv[i].rid;
         commit_valid = tv[i].cv; commit_opcode = tv[i].cop;
         commit_id = tv[i].cid; true_condition = tv[i].tc;
         pred_miss = tv[i].pm; clear = tv[i].clr;
         #2;
         chk($sformatf("v%0d pred", i), pred_condition, tv[i].e_pred);
         chk($sformatf("v%0d q_ready", i), q_ready, tv[i].e_rdy);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d flush", i), flush_req, tv[i].e_flush);
         chk($sformatf("v%0d n_branches", i), n_branches, tv[i].e_nb);
         chk($sformatf("v%0d n_misses", i), n_misses, tv[i].e_nm);
      end

      // Asynchronous reset while flush_req is high, between edges.
      idle_inputs();
      #1;
      nrst = 0;
      #1;
      chk("async flush", flush_req, 0);
      chk("async n_branches", n_branches, 0);
      chk("async n_misses", n_misses, 0);
      chk("async q_ready", q_ready, 0);
      @(negedge clk);
      nrst = 1;
      q_valid = 1; q_opcode = I_BEQ; q_pc = 16'h0009;
      #1;
      chk("post-reset pred idx9", pred_condition, 0);
      chk("post-reset q_ready", q_ready, 1);
      q_pc = 16'h0005;
      #1;
      chk("post-reset pred idx5", pred_condition, 0);
      @(posedge clk);
      #1;
      chk("post-reset flush", flush_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
